// File: rtl/issue_pkg.sv
// Shared class, dispatch-bit and FSM definitions for the issue sequencer.
package issue_pkg;

  localparam int unsigned NUM_CLS = 6;

  localparam int unsigned CLS_ALU = 0;
  localparam int unsigned CLS_MUL = 1;
  localparam int unsigned CLS_DIV = 2;
  localparam int unsigned CLS_LD  = 3;
  localparam int unsigned CLS_ST  = 4;
  localparam int unsigned CLS_JMP = 5;

  typedef logic [NUM_CLS-1:0] cls_oh_t;

  localparam int unsigned DISP_ALU    = 0;
  localparam int unsigned DISP_MUL    = 1;
  localparam int unsigned DISP_DIV    = 2;
  localparam int unsigned DISP_LOAD   = 3;
  localparam int unsigned DISP_STORE  = 4;
  localparam int unsigned DISP_UJUMP  = 5;
  localparam int unsigned DISP_BRANCH = 6;

  typedef logic [6:0] dec_disp_t;

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_CTRL = 1'b1
  } issue_state_e;

  // Branches and unconditional jumps share the single JMP class.
  function automatic cls_oh_t disp_to_class(input dec_disp_t d);
    cls_oh_t c;
    c          = '0;
    c[CLS_ALU] = d[DISP_ALU];
    c[CLS_MUL] = d[DISP_MUL];
    c[CLS_DIV] = d[DISP_DIV];
    c[CLS_LD]  = d[DISP_LOAD];
    c[CLS_ST]  = d[DISP_STORE];
    c[CLS_JMP] = d[DISP_BRANCH] | d[DISP_UJUMP];
    return c;
  endfunction

endpackage

// File: rtl/rs_credit_ctr.sv
// Occupancy counter for one reservation-station class; saturates at 0.
module rs_credit_ctr #(
  parameter int unsigned CAP = 2,
  localparam int unsigned W = $clog2(CAP + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alloc,
  input  logic         rel,
  output logic         full,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (alloc && !rel) begin
      count <= count + 1'b1;
    end else if (!alloc && rel && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign full = (count == W'(CAP));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst) rel |-> (count != '0));

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue sequencer: one-entry issue register, per-class RS credits, branch blocking.
// Optional statistics counters enabled by ISSUE_CTRL_STATS_EN.
module issue_ctrl
  import issue_pkg::*;
#(
  parameter int unsigned ALU_RS = 3,
  parameter int unsigned MUL_RS = 2,
  parameter int unsigned DIV_RS = 2,
  parameter int unsigned LD_RS  = 2,
  parameter int unsigned ST_RS  = 2,
  parameter int unsigned JMP_RS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_inst,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  output logic [31:0] dec_inst,
  input  logic [6:0]  dec_disp,
  output logic        issue_valid,
  output logic [5:0]  issue_class,
  output logic [31:0] issue_inst,
  output logic [31:0] issue_pc,
  input  logic [5:0]  rs_release,
  input  logic        ctrl_resolve,
  output logic        ctrl_busy
`ifdef ISSUE_CTRL_STATS_EN
  ,
  output logic [31:0] stat_issued,
  output logic [31:0] stat_rs_stall,
  output logic [31:0] stat_ctrl_stall
`endif
);

  function automatic int unsigned cap_of(input int unsigned idx);
    case (idx)
      CLS_ALU: return ALU_RS;
      CLS_MUL: return MUL_RS;
      CLS_DIV: return DIV_RS;
      CLS_LD:  return LD_RS;
      CLS_ST:  return ST_RS;
      default: return JMP_RS;
    endcase
  endfunction

  issue_state_e state;
  logic         ir_valid;
  logic [31:0]  ir_inst;
  logic [31:0]  ir_pc;
  cls_oh_t      cls;
  cls_oh_t      full;
  logic         run;
  logic         cls_known;
  logic         sel_full;
  logic         consumed;

  always_comb begin
    cls         = disp_to_class(dec_disp);
    run         = (state == RUN);
    cls_known   = |cls;
    sel_full    = |(cls & full);
    issue_valid = ir_valid & run & cls_known & ~sel_full;
    consumed    = issue_valid | (ir_valid & run & (dec_disp == '0));
    ctrl_busy   = (state == WAIT_CTRL);
    fetch_ready = (~ir_valid | consumed) & ~ctrl_busy;
    issue_class = issue_valid ? cls : '0;
  end

  assign dec_inst   = ir_inst;
  assign issue_inst = ir_inst;
  assign issue_pc   = ir_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_valid <= 1'b0;
      ir_inst  <= '0;
      ir_pc    <= '0;
    end else if (fetch_valid && fetch_ready) begin
      ir_valid <= 1'b1;
      ir_inst  <= fetch_inst;
      ir_pc    <= fetch_pc;
    end else if (consumed) begin
      ir_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:       if (issue_valid && cls[CLS_JMP]) state <= WAIT_CTRL;
        WAIT_CTRL: if (ctrl_resolve) state <= RUN;
        default:   state <= RUN;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CLS; i++) begin : g_cls
    localparam int unsigned CAP = cap_of(i);
    localparam int unsigned W   = $clog2(CAP + 1);
    logic [W-1:0] count;

    rs_credit_ctr #(.CAP(CAP)) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .alloc (issue_class[i]),
      .rel   (rs_release[i]),
      .full  (full[i]),
      .count (count)
    );

    a_cap: assert property (@(posedge clk) disable iff (rst) count <= W'(CAP));
  end

  a_resolve_in_wait: assert property (@(posedge clk) disable iff (rst) ctrl_resolve |-> ctrl_busy);
  a_disp_onehot: assert property (@(posedge clk) disable iff (rst) ir_valid |-> $onehot0(dec_disp));

`ifdef ISSUE_CTRL_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued     <= '0;
      stat_rs_stall   <= '0;
      stat_ctrl_stall <= '0;
    end else begin
      if (issue_valid) stat_issued <= stat_issued + 32'd1;
      if (ir_valid && run && cls_known && sel_full) stat_rs_stall <= stat_rs_stall + 32'd1;
      if (ir_valid && ctrl_busy) stat_ctrl_stall <= stat_ctrl_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios plus random traffic against a queue-free credit model.
module tb_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic [31:0] dec_inst;
  logic [6:0]  dec_disp;
  logic        issue_valid;
  logic [5:0]  issue_class;
  logic [31:0] issue_inst;
  logic [31:0] issue_pc;
  logic [5:0]  rs_release;
  logic        ctrl_resolve;
  logic        ctrl_busy;
`ifdef ISSUE_CTRL_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_rs_stall;
  logic [31:0] stat_ctrl_stall;
`endif

  int total = 0;
  int bad   = 0;

  // Reference state: one held instruction, credit counts per class, branch-pending flag.
  bit          m_v;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  int          m_cnt[6];
  bit          m_busy;
  int          cap[6] = '{3, 2, 2, 2, 2, 1};

  always #5 clk = ~clk;

  issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_valid  (fetch_valid),
    .fetch_inst   (fetch_inst),
    .fetch_pc     (fetch_pc),
    .fetch_ready  (fetch_ready),
    .dec_inst     (dec_inst),
    .dec_disp     (dec_disp),
    .issue_valid  (issue_valid),
    .issue_class  (issue_class),
    .issue_inst   (issue_inst),
    .issue_pc     (issue_pc),
    .rs_release   (rs_release),
    .ctrl_resolve (ctrl_resolve),
    .ctrl_busy    (ctrl_busy)
`ifdef ISSUE_CTRL_STATS_EN
    ,
    .stat_issued     (stat_issued),
    .stat_rs_stall   (stat_rs_stall),
    .stat_ctrl_stall (stat_ctrl_stall)
`endif
  );

  // Bench decoder: inst[2:0] selects 0=nop 1=add 2=mul 3=div 4=lw 5=sw 6=beq 7=jal.
  always_comb begin
    dec_disp = '0;
    case (dec_inst[2:0])
      3'd1: dec_disp = 7'b0000001;
      3'd2: dec_disp = 7'b0000010;
      3'd3: dec_disp = 7'b0000100;
      3'd4: dec_disp = 7'b0001000;
      3'd5: dec_disp = 7'b0010000;
      3'd6: dec_disp = 7'b1000000;
      3'd7: dec_disp = 7'b0100000;
      default: dec_disp = '0;
    endcase
  end

  function automatic int class_of(input logic [2:0] code);
    case (code)
      3'd0: return -1;
      3'd1: return 0;
      3'd2: return 1;
      3'd3: return 2;
      3'd4: return 3;
      3'd5: return 4;
      default: return 5;
    endcase
  endfunction

  task automatic model_reset();
    m_v    = 1'b0;
    m_inst = '0;
    m_pc   = '0;
    m_busy = 1'b0;
    for (int c = 0; c < 6; c++) m_cnt[c] = 0;
  endtask

  // One clock cycle: drive, compare at negedge, advance the model at posedge.
  task automatic step(input bit fv, input logic [2:0] code, input logic [5:0] rel, input bit res,
                      output logic o_valid, output logic [5:0] o_class);
    int          c;
    bit          e_issue, e_drop, e_ready;
    logic [5:0]  e_class;
    logic [31:0] r, f_inst, f_pc;
    r            = $urandom();
    f_inst       = {r[31:3], code};
    f_pc         = $urandom();
    fetch_valid  = fv;
    fetch_inst   = f_inst;
    fetch_pc     = f_pc;
    rs_release   = rel;
    ctrl_resolve = res;
    @(negedge clk);
    c       = m_v ? class_of(m_inst[2:0]) : -1;
    e_issue = m_v && !m_busy && (c >= 0) && (m_cnt[c] < cap[c]);
    e_drop  = m_v && !m_busy && (c < 0);
    e_ready = (!m_v || e_issue || e_drop) && !m_busy;
    e_class = e_issue ? 6'(1 << c) : 6'b0;
    total++;
    if (issue_valid !== e_issue) begin
      bad++;
      $display("FAIL issue_valid t=%0t got=%0b exp=%0b", $time, issue_valid, e_issue);
    end
    total++;
    if (issue_class !== e_class) begin
      bad++;
      $display("FAIL issue_class t=%0t got=%b exp=%b", $time, issue_class, e_class);
    end
    total++;
    if (fetch_ready !== e_ready) begin
      bad++;
      $display("FAIL fetch_ready t=%0t got=%0b exp=%0b", $time, fetch_ready, e_ready);
    end
    total++;
    if (ctrl_busy !== m_busy) begin
      bad++;
      $display("FAIL ctrl_busy t=%0t got=%0b exp=%0b", $time, ctrl_busy, m_busy);
    end
    total++;
    if (dec_inst !== m_inst) begin
      bad++;
      $display("FAIL dec_inst t=%0t got=%h exp=%h", $time, dec_inst, m_inst);
    end
    if (e_issue) begin
      total++;
      if (issue_inst !== m_inst || issue_pc !== m_pc) begin
        bad++;
        $display("FAIL issue_payload t=%0t got=%h/%h exp=%h/%h", $time, issue_inst, issue_pc, m_inst, m_pc);
      end
    end
    o_valid = issue_valid;
    o_class = issue_class;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      if (e_issue && c == k) m_cnt[k]++;
      if (rel[k] && m_cnt[k] > 0) m_cnt[k]--;
    end
    if (!m_busy && e_issue && c == 5) m_busy = 1'b1;
    else if (m_busy && res) m_busy = 1'b0;
    if (fv && e_ready) begin
      m_v    = 1'b1;
      m_inst = f_inst;
      m_pc   = f_pc;
    end else if (e_issue || e_drop) begin
      m_v = 1'b0;
    end
    #1;
  endtask

  task automatic drain();
    logic       v;
    logic [5:0] cl, rel;
    bit         done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      done = !m_v && !m_busy;
      for (int k = 0; k < 6; k++) if (m_cnt[k] != 0) done = 1'b0;
      if (!done) begin
        for (int k = 0; k < 6; k++) rel[k] = (m_cnt[k] > 0);
        step(1'b0, 3'd0, rel, m_busy, v, cl);
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_timeout got=busy exp=idle");
    end
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst = 1'b1;
    #1;
    total++;
    if (issue_valid !== 1'b0 || issue_class !== 6'b0 || fetch_ready !== 1'b1 || ctrl_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s got=v%0b c%b r%0b b%0b exp=v0 c000000 r1 b0", tag, issue_valid, issue_class, fetch_ready, ctrl_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    fetch_valid  = 1'b0;
    fetch_inst   = '0;
    fetch_pc     = '0;
    rs_release   = '0;
    ctrl_resolve = 1'b0;
    #12;
    total++;
    if (issue_valid !== 1'b0 || issue_class !== 6'b0) begin
      bad++;
      $display("FAIL reset_issue got=%0b/%b exp=0/000000", issue_valid, issue_class);
    end
    total++;
    if (fetch_ready !== 1'b1 || ctrl_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=ready%0b busy%0b exp=ready1 busy0", fetch_ready, ctrl_busy);
    end
    total++;
    if (dec_inst !== 32'h0) begin
      bad++;
      $display("FAIL reset_ir got=%h exp=0", dec_inst);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_back_to_back();
    logic       v;
    logic [5:0] cl;
    step(1'b1, 3'd1, 6'b0, 1'b0, v, cl);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd1, 6'b0, 1'b0, v, cl);
      total++;
      if (v !== 1'b1) begin
        bad++;
        $display("FAIL alu_b2b_%0d got=%0b exp=1", i, v);
      end
    end
    step(1'b0, 3'd0, 6'b0, 1'b0, v, cl);
    total++;
    if (v !== 1'b0) begin
      bad++;
      $display("FAIL alu_full_hold got=%0b exp=0", v);
    end
    step(1'b0, 3'd0, 6'b000001, 1'b0, v, cl);
    total++;
    if (v !== 1'b0) begin
      bad++;
      $display("FAIL alu_release_same_cycle got=%0b exp=0", v);
    end
    step(1'b0, 3'd0, 6'b0, 1'b0, v, cl);
    total++;
    if (v !== 1'b1 || cl !== 6'b000001) begin
      bad++;
      $display("FAIL alu_after_release got=%0b/%b exp=1/000001", v, cl);
    end
    drain();
  endtask

  task automatic test_noop();
    logic       v;
    logic [5:0] cl;
    step(1'b1, 3'd0, 6'b0, 1'b0, v, cl);
    step(1'b1, 3'd1, 6'b0, 1'b0, v, cl);
    total++;
    if (v !== 1'b0) begin
      bad++;
      $display("FAIL noop_no_issue got=%0b exp=0", v);
    end
    step(1'b0, 3'd0, 6'b0, 1'b0, v, cl);
    total++;
    if (v !== 1'b1 || cl !== 6'b000001) begin
      bad++;
      $display("FAIL noop_next_issue got=%0b/%b exp=1/000001", v, cl);
    end
    drain();
  endtask

  task automatic test_branch();
    logic       v;
    logic [5:0] cl;
    step(1'b1, 3'd6, 6'b0, 1'b0, v, cl);
    step(1'b1, 3'd4, 6'b0, 1'b0, v, cl);
    total++;
    if (v !== 1'b1 || cl !== 6'b100000) begin
      bad++;
      $display("FAIL beq_issue got=%0b/%b exp=1/100000", v, cl);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 3'd1, 6'b0, 1'b0, v, cl);
    total++;
    if (ctrl_busy !== 1'b1) begin
      bad++;
      $display("FAIL beq_busy got=%0b exp=1", ctrl_busy);
    end
    step(1'b0, 3'd0, 6'b0, 1'b1, v, cl);
    total++;
    if (v !== 1'b0) begin
      bad++;
      $display("FAIL lw_resolve_cycle got=%0b exp=0", v);
    end
    step(1'b0, 3'd0, 6'b0, 1'b0, v, cl);
    total++;
    if (v !== 1'b1 || cl !== 6'b001000) begin
      bad++;
      $display("FAIL lw_after_resolve got=%0b/%b exp=1/001000", v, cl);
    end
    drain();
  endtask

  task automatic test_mul_same_cycle();
    logic       v;
    logic [5:0] cl;
    step(1'b1, 3'd2, 6'b0, 1'b0, v, cl);
    step(1'b1, 3'd2, 6'b0, 1'b0, v, cl);
    step(1'b1, 3'd2, 6'b000010, 1'b0, v, cl);
    step(1'b1, 3'd2, 6'b0, 1'b0, v, cl);
    total++;
    if (v !== 1'b1) begin
      bad++;
      $display("FAIL mul_after_balance got=%0b exp=1", v);
    end
    step(1'b0, 3'd0, 6'b0, 1'b0, v, cl);
    total++;
    if (v !== 1'b0) begin
      bad++;
      $display("FAIL mul_full got=%0b exp=0", v);
    end
    drain();
  endtask

  task automatic test_div_reset();
    logic       v;
    logic [5:0] cl;
    for (int i = 0; i < 3; i++) step(1'b1, 3'd3, 6'b0, 1'b0, v, cl);
    for (int i = 0; i < 2; i++) step(1'b0, 3'd0, 6'b0, 1'b0, v, cl);
    total++;
    if (v !== 1'b0) begin
      bad++;
      $display("FAIL div_third_waits got=%0b exp=0", v);
    end
    async_reset_check("div_async_reset");
    for (int i = 0; i < 3; i++) step(1'b1, 3'd3, 6'b0, 1'b0, v, cl);
    step(1'b0, 3'd0, 6'b0, 1'b0, v, cl);
    drain();
  endtask

`ifdef ISSUE_CTRL_STATS_EN
  task automatic test_stats();
    logic       v;
    logic [5:0] cl;
    async_reset_check("stats_reset");
    for (int i = 0; i < 3; i++) step(1'b1, 3'd3, 6'b0, 1'b0, v, cl);
    for (int i = 0; i < 5; i++) step(1'b0, 3'd0, 6'b0, 1'b0, v, cl);
    total++;
    if (stat_rs_stall !== 32'd5 || stat_issued !== 32'd2 || stat_ctrl_stall !== 32'd0) begin
      bad++;
      $display("FAIL stats got=%0d/%0d/%0d exp=2/5/0", stat_issued, stat_rs_stall, stat_ctrl_stall);
    end
    drain();
  endtask
`endif

  task automatic test_random();
    logic       v;
    logic [5:0] cl, rel;
    bit         fv, res;
    logic [2:0] code;
    for (int i = 0; i < 400; i++) begin
      fv   = ($urandom_range(0, 3) != 0);
      code = 3'($urandom_range(0, 7));
      for (int k = 0; k < 6; k++) rel[k] = (m_cnt[k] > 0) && ($urandom_range(0, 2) == 0);
      res = m_busy && ($urandom_range(0, 3) == 0);
      step(fv, code, rel, res, v, cl);
    end
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_back_to_back();
    test_noop();
    test_branch();
    test_mul_same_cycle();
    test_div_reset();
`ifdef ISSUE_CTRL_STATS_EN
    test_stats();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- In-order issue sequencer between fetch and the reservation stations (RS) of the Tomasulo core.
- Holds one fetched instruction in an issue register (IR) and drives the decoder combinationally from IR.
- Issues to the decoded RS class only when that class has a free entry; otherwise stalls fetch.
- Blocks issue after any branch or jump until the jump unit resolves it.

Parameters:
- ALU_RS, 3, ALU reservation-station entries
- MUL_RS, 2, multiplier RS entries
- DIV_RS, 2, divider RS entries
- LD_RS, 2, load-buffer entries
- ST_RS, 2, store-buffer entries
- JMP_RS, 1, jump/branch RS entries (branch and ujump share it)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- fetch_valid  in  1  fetch offers inst/pc
- fetch_inst  in  32  instruction
- fetch_pc  in  32  its PC
- fetch_ready  out  1  IR can accept this cycle
- dec_inst  out  32  IR instruction, wired to the decoder
- dec_disp  in  7  decoder dispatch bits {branch,ujump,store,load,div,mul,ALU}
- issue_valid  out  1  allocation pulse this cycle
- issue_class  out  6  one-hot {JMP,ST,LD,DIV,MUL,ALU}
- issue_inst  out  32  IR instruction
- issue_pc  out  32  IR PC
- rs_release  in  6  per-class one-cycle release pulses, same bit order as issue_class
- ctrl_resolve  in  1  jump unit has resolved the outstanding branch/jump
- ctrl_busy  out  1  FSM in WAIT_CTRL

Behaviour:
- Reset values: IR valid=0, IR inst=0, IR pc=0, all occupancy counters=0, FSM=RUN.
  Outputs at reset: issue_valid=0, issue_class=0, ctrl_busy=0, fetch_ready=1.
- Class map: ALU→ALU; mul→MUL; div→DIV; load→LD; store→ST; branch|ujump→JMP.
  At most one dec_disp bit is set. All-zero means "no-op" (rd=x0 writes, illegal encodings).
- can_issue = IR valid & FSM==RUN & selected class count < capacity.
  count is the registered value; a same-cycle release is not visible until the next cycle.
- issue_valid = can_issue & class known. It is combinational from registers and dec_disp.
- IR consumed when (issue_valid) or (IR valid & dec_disp==0 & FSM==RUN). A no-op is dropped in 1 cycle with no RS allocation.
- fetch_ready = ~IR valid | IR consumed. IR loads fetch_inst/pc on fetch_valid & fetch_ready; otherwise it clears valid if consumed.
  Throughput: 1 instruction/cycle when RS are available.
- Counters: next = count + alloc − release. Width = clog2(capacity+1).
  Simultaneous alloc and release leaves the count unchanged.
  Release at count 0 is an error: the counter saturates at 0 and an assertion fires.
- FSM RUN: on issue_valid with class JMP → WAIT_CTRL.
- FSM WAIT_CTRL: no issue, no no-op drop. IR may still fill once. ctrl_busy=1.
  On ctrl_resolve → RUN; issue may resume the following cycle.
- ctrl_resolve in RUN: ignored (assertion).
- A jump issued and resolved in the same cycle: ctrl_resolve is ignored because the FSM is in RUN, and the jump then deadlocks in WAIT_CTRL. This case is illegal, and the jump unit takes ≥1 cycle.
- Redirect after a resolved jump is owned by fetch. fetch_pc of the next loaded instruction is trusted.
  An IR already holding a wrong-path instruction is not allowed: fetch must not present a new instruction while ctrl_busy.
  fetch_ready is therefore also gated with ~ctrl_busy.
- Reset mid-operation: all state clears immediately (async). Pending RS contents are owned by the RS and are reset separately.

Optional Feature:
- Macro ISSUE_CTRL_STATS_EN.
- Defined: adds three 32-bit wrapping counters and outputs stat_issued, stat_rs_stall (IR valid, RUN, class full) and stat_ctrl_stall (IR valid, WAIT_CTRL). All reset to 0.
- Undefined: these ports and registers are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package issue_pkg holds:
  - class index localparams (CLS_ALU=0 … CLS_JMP=5)
  - the 6-bit one-hot class encoding
  - the dec_disp bit order
  - FSM state encoding (RUN=0, WAIT_CTRL=1)
- One sub-module: rs_credit_ctr (parameter CAP; inputs alloc, release; outputs full, count), instantiated six times.

Test Plan:
- Back-to-back ADDs, rd≠x0, ALU_RS=3, no release → 3 issues on consecutive cycles. 4th ADD holds, fetch_ready=0. One ALU release → 4th issues exactly one cycle later.
- ADDI x0,x0,0 (dec_disp=0) → dropped in 1 cycle. issue_valid stays 0, counts unchanged, next instruction enters IR.
- BEQ issued → ctrl_busy=1 and the following LW stalls. Pulse ctrl_resolve after 4 cycles → LW issues the cycle after, class LD (6'b001000).
- MUL issued and MUL release in the same cycle with count=1 → count stays 1.
- With DIV_RS=2, two DIVs fill the class and a 3rd waits; then assert rst asynchronously mid-stall → issue_valid=0, counts 0, fetch_ready=1 before the next edge.
- With ISSUE_CTRL_STATS_EN: the scenario above with 5 stalled cycles → stat_rs_stall=5, stat_issued=2.
